// File: rtl/fifo_serial_pkg.sv
// fifo_serial_pkg: shared types and constants for the FIFO-to-serial transmitter.
// Optional feature macro: FIFO_SERIAL_TX_PARITY_EN (adds the PARITY state).
package fifo_serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
`ifdef FIFO_SERIAL_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Clock cycles from START entry to the end of the last stop bit.
  function automatic int frame_cycles(input int data_w, input int clks_per_bit,
                                      input int stop_bits, input int parity_en);
    return (1 + data_w + stop_bits + parity_en) * clks_per_bit;
  endfunction

endpackage

// File: rtl/fifo_tx_baud_gen.sv
// fifo_tx_baud_gen: free-running 8-bit baud counter with synchronous clear.
// bit_tick pulses for one cycle on the cycle the counter wraps.
// Optional feature macro: FIFO_SERIAL_TX_PARITY_EN (no effect in this file).
module fifo_tx_baud_gen
  import fifo_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic clear,
  output logic bit_tick
);

  localparam logic [7:0] WRAP_VAL = 8'(CLKS_PER_BIT - 1);

  logic [7:0] r_cnt;
  logic       w_wrap;

  assign w_wrap   = (r_cnt == WRAP_VAL);
  assign bit_tick = ena && !clear && w_wrap;

  // Count 0..CLKS_PER_BIT-1; clear restarts a bit period, ena=0 freezes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else if (ena) begin
      if (clear || w_wrap) begin
        r_cnt <= 8'd0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: pops words from a FIFO and shifts each out as an async
// serial frame (start, DATA_W bits LSB-first, optional even parity, stop).
// Optional feature macro: FIFO_SERIAL_TX_PARITY_EN (even parity bit before stop).
module fifo_serial_tx
  import fifo_serial_pkg::*;
#(
  parameter int DATA_W       = 6,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy
);

  localparam int BIT_CNT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(DATA_W - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP_BIT = BIT_CNT_W'(STOP_BITS - 1);

  tx_state_t             r_state, w_state_next;
  logic [DATA_W-1:0]     r_shift, w_shift_next;
  logic [BIT_CNT_W-1:0]  r_bit_cnt, w_bit_cnt_next;
  logic                  r_tx, w_tx_next;
  logic                  r_rd_en, w_rd_en_next;
  logic                  r_busy, w_busy_next;
  logic                  w_bit_tick;
  logic                  w_baud_clear;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  logic                  r_parity, w_parity_next;
`endif

  assign w_baud_clear = (r_state == LOAD);

  fifo_tx_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .clear    (w_baud_clear),
    .bit_tick (w_bit_tick)
  );

  // Next-state, shift/counter updates and the next values of the registered outputs.
  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    w_parity_next  = r_parity;
`endif

    case (r_state)
      IDLE: begin
        if (!fifo_empty) begin
          w_state_next = POP;
        end
      end
      POP: begin
        // Leave only once the pulse has actually been on the wire during an
        // enabled edge; a stalled pop re-raises the strobe instead.
        if (r_rd_en) begin
          w_state_next = LOAD;
        end
      end
      LOAD: begin
        w_shift_next = fifo_data;
`ifdef FIFO_SERIAL_TX_PARITY_EN
        w_parity_next = ^fifo_data;
`endif
        w_state_next = START;
      end
      START: begin
        if (w_bit_tick) begin
          w_state_next   = DATA;
          w_bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (w_bit_tick) begin
          w_shift_next = r_shift >> 1;
          if (r_bit_cnt == LAST_DATA_BIT) begin
            w_bit_cnt_next = '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
            w_state_next   = PARITY;
`else
            w_state_next   = STOP;
`endif
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end
        end
      end
`ifdef FIFO_SERIAL_TX_PARITY_EN
      PARITY: begin
        if (w_bit_tick) begin
          w_state_next   = STOP;
          w_bit_cnt_next = '0;
        end
      end
`endif
      STOP: begin
        if (w_bit_tick) begin
          if (r_bit_cnt == LAST_STOP_BIT) begin
            w_state_next   = IDLE;
            w_bit_cnt_next = '0;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so the registers line up with r_state.
    w_tx_next = IDLE_LEVEL;
    case (w_state_next)
      START:   w_tx_next = START_LEVEL;
      DATA:    w_tx_next = w_shift_next[0];
`ifdef FIFO_SERIAL_TX_PARITY_EN
      PARITY:  w_tx_next = w_parity_next;
`endif
      default: w_tx_next = IDLE_LEVEL;
    endcase
    w_rd_en_next = (w_state_next == POP);
    w_busy_next  = (w_state_next != IDLE);
  end

  // State and output registers; ena=0 freezes everything and drops the pop strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_tx      <= IDLE_LEVEL;
      r_rd_en   <= 1'b0;
      r_busy    <= 1'b0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else if (ena) begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_tx      <= w_tx_next;
      r_rd_en   <= w_rd_en_next;
      r_busy    <= w_busy_next;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      r_parity  <= w_parity_next;
`endif
    end else begin
      r_rd_en <= 1'b0;
    end
  end

  assign fifo_rd_en = r_rd_en;
  assign tx         = r_tx;
  assign busy       = r_busy;

endmodule
